// File: rtl/tlc_timer.sv
// Prescaled interval timer: a tick every PRESCALE clk cycles while running, and a
// one-cycle timer_done pulse each time the tick count reaches final_value.
module tlc_timer #(
    parameter int N        = 13,
    parameter int PRESCALE = 50000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         timer_reset,
    input  logic [N-1:0] final_value,
    output logic         timer_done,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    // timer_reset suppresses the tick so a coincident clear never yields a done pulse
    assign tick = (state == RUN) && (prescaler == PMAX) && !timer_reset;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            prescaler  <= '0;
            count      <= '0;
            timer_done <= 1'b0;
            busy       <= 1'b0;
        end else if (timer_reset) begin
            prescaler  <= '0;
            count      <= '0;
            timer_done <= 1'b0;
            state      <= enable ? RUN : IDLE;
            busy       <= enable;
        end else begin
            timer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    prescaler <= (prescaler == PMAX) ? '0 : prescaler + 1'b1;
                    if (tick) begin
                        // >= so a final_value lowered below count expires on this tick
                        if (count >= final_value) begin
                            count      <= '0;
                            timer_done <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    if (!enable) state <= HOLD;
                end
                HOLD: begin
                    if (enable) state <= RUN;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlc_timer.sv
// Directed bench for tlc_timer with PRESCALE=4, N=13: a vector table for reset and
// the basic interval, then hand-written sequences for zero interval, pause, clear, shrink.
module tb_tlc_timer;

    localparam int N  = 13;
    localparam int PS = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         timer_reset;
    logic [N-1:0] final_value;
    logic         timer_done;
    logic [N-1:0] count;
    logic         tick;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    tlc_timer #(.N(N), .PRESCALE(PS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .timer_reset(timer_reset),
        .final_value(final_value),
        .timer_done (timer_done),
        .count      (count),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rn;
        logic         en;
        logic         tr;
        logic [N-1:0] fv;
        logic         et;
        logic         ed;
        logic         eb;
        logic [N-1:0] ec;
        logic         ct;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, compare on the falling edge.
    task automatic apply(input string nm, input vec_t v);
        reset_n     = v.rn;
        enable      = v.en;
        timer_reset = v.tr;
        final_value = v.fv;
        @(negedge clk);
        if (v.ct) chk({nm, ".tick"}, {31'd0, tick}, {31'd0, v.et});
        chk({nm, ".done"},  {31'd0, timer_done}, {31'd0, v.ed});
        chk({nm, ".busy"},  {31'd0, busy}, {31'd0, v.eb});
        chk({nm, ".count"}, {19'd0, count}, {19'd0, v.ec});
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rn, en, tr, input int fv,
                                input logic et, ed, eb, input int ec);
        vec_t v;
        v.rn = rn; v.en = en; v.tr = tr; v.fv = N'(fv);
        v.et = et; v.ed = ed; v.eb = eb; v.ec = N'(ec); v.ct = 1'b1;
        return v;
    endfunction

    // Expected outputs in RUN cycle k (k=1 first cycle after a clean start) for final value f.
    function automatic vec_t run_vec(input int f, input logic en, input int k);
        return mk(1'b1, en, 1'b0, f, (k % PS) == 0,
                  (k > 1) && ((k - 1) % (PS * (f + 1)) == 0), 1'b1,
                  ((k - 1) / PS) % (f + 1));
    endfunction

    task automatic run(input string nm, input int f, input logic en, input int k1, input int k2);
        for (int k = k1; k <= k2; k++)
            apply($sformatf("%s[%0d]", nm, k), run_vec(f, en, k));
    endtask

    // One timer_reset cycle with enable=1; only the tick suppression is observable here.
    task automatic clear_cycle(input string nm, input int f);
        reset_n     = 1'b1;
        enable      = 1'b1;
        timer_reset = 1'b1;
        final_value = N'(f);
        @(negedge clk);
        chk({nm, ".tick"}, {31'd0, tick}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);
        tbl[2] = mk(1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 26; k++) tbl[k + 2] = run_vec(2, 1'b1, k);

        reset_n     = 1'b0;
        enable      = 1'b1;
        timer_reset = 1'b0;
        final_value = N'(2);
        repeat (3) @(posedge clk);
        #1;

        // Reset, idle with enable low, start-up and two full intervals with final_value=2
        for (int i = 0; i < 29; i++) apply($sformatf("basic[%0d]", i), tbl[i]);

        // Zero interval: done after every tick, count pinned at 0
        clear_cycle("zero_clr", 0);
        run("zero", 0, 1'b1, 1, 13);

        // Pause at count=1, prescaler=2 for 10 cycles of enable=0
        clear_cycle("pause_clr", 2);
        run("pause_go", 2, 1'b1, 1, 5);
        run("pause_drop", 2, 1'b0, 6, 6);
        for (int i = 0; i < 9; i++)
            apply($sformatf("pause_hold[%0d]", i), mk(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1));
        apply("pause_wake", mk(1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1));
        run("pause_resume", 2, 1'b1, 7, 13);

        // timer_reset coincident with the expiring tick
        clear_cycle("clr_start", 2);
        run("clr_pre", 2, 1'b1, 1, 11);
        apply("clr_hit", mk(1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 2));
        run("clr_post", 2, 1'b1, 1, 13);

        // Shrink final_value below count mid-interval; a non-tick glitch has no effect
        clear_cycle("shr_clr", 4999);
        run("shr_a", 4999, 1'b1, 1, 28);
        apply("shr_glitch", mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 7));
        apply("shr_r30", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 7));
        apply("shr_r31", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 7));
        apply("shr_tick", mk(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 7));
        apply("shr_done", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 0));

        // Reset asserted on a tick cycle overrides enable, timer_reset and the tick
        apply("mid_r34", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 0));
        apply("mid_r35", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 0));
        v = mk(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 0);
        v.ct = 1'b0;
        apply("mid_rst", v);
        apply("mid_after", mk(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0));
        run("post_rst", 1, 1'b1, 1, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
